// File: rtl/ysyx_220066_fetch_ctrl.sv
// ysyx_220066_fetch_ctrl
// Instruction-fetch sequencer. Owns the fetch PC, issues one request at a time
// to the instruction memory, squashes fetches on redirect and holds the fetched
// instruction for decode while decode stalls.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   redirect_valid/_pc        jump/branch target (wins over everything else)
//   id_block                  decode stall, held instruction must not advance
//   imem_req_valid/_ready     request handshake, imem_req_addr = fetch PC
//   imem_rsp_valid/_data      one response per accepted request
//   if_valid/_pc/_instr       instruction presented to decode
//   if_misalign               misaligned-target fault (only with the macro)
//
// Build option: IFU_MISALIGN_TRAP_EN
//   defined     a misaligned redirect target produces a fault instruction
//               (nop encoding, if_misalign=1) instead of a memory request
//   undefined   redirect_pc[1:0] are ignored and the if_misalign port is absent
//
// state  | meaning
// IDLE   | first cycle after reset, no request yet
// REQ    | request presented, waiting for imem_req_ready
// WAIT   | request accepted, waiting for the response
// HOLD   | instruction presented to decode until consumed or squashed
module ysyx_220066_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        id_block,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    output logic        if_misalign
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state;
    logic [63:0] pc_r;
    logic [63:0] pend_pc;
    logic [63:0] held_pc;
    logic [31:0] held_instr;
    logic        drop;
    logic        held_valid;
    logic        req_valid_r;

    logic [63:0] tgt_pc;
    logic [63:0] latest_pc;

`ifdef IFU_MISALIGN_TRAP_EN
    logic        tgt_mis;
    logic        pend_mis;
    logic        latest_mis;
    logic        mis_r;
    logic        fault_go;

    assign tgt_pc     = redirect_pc;
    assign tgt_mis    = redirect_pc[1:0] != 2'b00;
    assign latest_mis = redirect_valid ? tgt_mis : pend_mis;

    // A misaligned target never reaches memory; it turns into a fault
    // instruction the moment it would otherwise become the fetch PC.
    always_comb begin
        fault_go = 1'b0;
        case (state)
            S_IDLE:  fault_go = redirect_valid && tgt_mis;
            S_WAIT:  fault_go = imem_rsp_valid && (drop || redirect_valid) && latest_mis;
            S_HOLD:  fault_go = redirect_valid && tgt_mis;
            default: fault_go = 1'b0;
        endcase
    end

    assign if_misalign = mis_r;
`else
    // Mask rather than slice so every redirect_pc bit is consumed.
    assign tgt_pc = redirect_pc & ~64'h3;
`endif

    // The most recent target: this cycle's redirect, else the one saved earlier.
    assign latest_pc = redirect_valid ? tgt_pc : pend_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc_r        <= RESET_PC;
            pend_pc     <= RESET_PC;
            held_pc     <= RESET_PC;
            held_instr  <= 32'h0;
            drop        <= 1'b0;
            held_valid  <= 1'b0;
            req_valid_r <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
            pend_mis    <= 1'b0;
            mis_r       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        pc_r <= tgt_pc;
                    end
                    state       <= S_REQ;
                    req_valid_r <= 1'b1;
                end

                S_REQ: begin
                    // The presented request is never withdrawn; a redirect only
                    // marks its response for discard.
                    if (redirect_valid) begin
                        pend_pc <= tgt_pc;
                        drop    <= 1'b1;
`ifdef IFU_MISALIGN_TRAP_EN
                        pend_mis <= tgt_mis;
`endif
                    end
                    if (imem_req_ready) begin
                        state       <= S_WAIT;
                        req_valid_r <= 1'b0;
                    end
                end

                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop || redirect_valid) begin
                            pc_r        <= latest_pc;
                            drop        <= 1'b0;
                            state       <= S_REQ;
                            req_valid_r <= 1'b1;
                        end else begin
                            held_instr <= imem_rsp_data;
                            held_pc    <= pc_r;
                            pc_r       <= pc_r + 64'd4;
                            held_valid <= 1'b1;
                            state      <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        pend_pc <= tgt_pc;
                        drop    <= 1'b1;
`ifdef IFU_MISALIGN_TRAP_EN
                        pend_mis <= tgt_mis;
`endif
                    end
                end

                S_HOLD: begin
                    if (redirect_valid) begin
                        held_valid  <= 1'b0;
                        pc_r        <= tgt_pc;
                        state       <= S_REQ;
                        req_valid_r <= 1'b1;
`ifdef IFU_MISALIGN_TRAP_EN
                        mis_r       <= 1'b0;
`endif
                    end else if (!id_block) begin
                        held_valid  <= 1'b0;
                        state       <= S_REQ;
                        req_valid_r <= 1'b1;
`ifdef IFU_MISALIGN_TRAP_EN
                        mis_r       <= 1'b0;
`endif
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    req_valid_r <= 1'b0;
                    held_valid  <= 1'b0;
                end
            endcase

`ifdef IFU_MISALIGN_TRAP_EN
            // Overrides the normal transition above. Fetching resumes at the
            // word after the faulting target once the fault is consumed.
            if (fault_go) begin
                state       <= S_HOLD;
                held_valid  <= 1'b1;
                held_pc     <= latest_pc;
                held_instr  <= 32'h0000_0013;
                mis_r       <= 1'b1;
                req_valid_r <= 1'b0;
                drop        <= 1'b0;
                pc_r        <= (latest_pc & ~64'h3) + 64'd4;
            end
`endif
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = pc_r;
    // A redirect squashes the presented instruction in the same cycle.
    assign if_valid       = held_valid & ~redirect_valid;
    assign if_pc          = held_pc;
    assign if_instr       = held_instr;

endmodule

// File: tb/tb_ysyx_220066_fetch_ctrl.sv
// Testbench for ysyx_220066_fetch_ctrl. A small memory model answers accepted
// requests after a programmable latency with data = addr[31:0] + 32'h1000_0000.
// Expected request addresses and delivered instructions are queued by the
// stimulus; a monitor compares them as the DUT presents them.
module tb_ysyx_220066_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_block;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
`ifdef IFU_MISALIGN_TRAP_EN
    logic        if_misalign;
`endif

    ysyx_220066_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_block       (id_block),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
`ifdef IFU_MISALIGN_TRAP_EN
        ,
        .if_misalign    (if_misalign)
`endif
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
    } if_exp_t;

    logic [63:0] exp_req_q[$];
    if_exp_t     exp_if_q[$];

    int checks   = 0;
    int failures = 0;
    int rsp_lat  = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    // ---------------- memory model ----------------
    logic        acc_n;
    logic [63:0] addr_n;
    always @(negedge clk) begin
        acc_n  = imem_req_valid && imem_req_ready && !rst;
        addr_n = imem_req_addr;
    end

    initial begin : mem_model
        logic        pend;
        int          cnt;
        logic [63:0] paddr;
        pend = 1'b0;
        cnt = 0;
        paddr = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (acc_n) begin
                pend  = 1'b1;
                cnt   = rsp_lat;
                paddr = addr_n;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = paddr[31:0] + 32'h1000_0000;
                    pend = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req_valid && imem_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL req_unexpected got=%h exp=none", imem_req_addr);
                end else begin
                    chk("req_addr", imem_req_addr, exp_req_q.pop_front());
                end
            end
            if (if_valid && !id_block) begin
                if (exp_if_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL if_unexpected got_pc=%h got_instr=%h exp=none", if_pc, if_instr);
                end else begin
                    if_exp_t e;
                    e = exp_if_q.pop_front();
                    chk("if_pc", if_pc, e.pc);
                    chk("if_instr", {32'h0, if_instr}, {32'h0, e.instr});
`ifdef IFU_MISALIGN_TRAP_EN
                    chk("if_misalign", {63'h0, if_misalign}, {63'h0, e.mis});
`endif
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_if(input logic [63:0] pc, input logic [31:0] instr, input logic mis);
        if_exp_t e;
        e.pc = pc;
        e.instr = instr;
        e.mis = mis;
        exp_if_q.push_back(e);
    endtask

    task automatic wait_req_drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_req_q.size() == 0) begin
                checks++;
                return;
            end
            step();
        end
        checks++;
        failures++;
        $display("FAIL req_drain_timeout got=%0d exp=0 pending", exp_req_q.size());
    endtask

    task automatic wait_if_drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_if_q.size() == 0) begin
                checks++;
                return;
            end
            step();
        end
        checks++;
        failures++;
        $display("FAIL if_drain_timeout got=%0d exp=0 pending", exp_if_q.size());
    endtask

    task automatic wait_if_valid();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if_valid) begin
                checks++;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL if_valid_timeout got=0 exp=1");
    endtask

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        summary();
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        id_block       = 1'b0;
        imem_req_ready = 1'b0;
        repeat (3) step();

        // Reset values
        @(negedge clk);
        chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("rst_req_addr", imem_req_addr, 64'h8000_0000);
        chk("rst_if_valid", {63'h0, if_valid}, 64'h0);
        chk("rst_if_pc", if_pc, 64'h8000_0000);
        chk("rst_if_instr", {32'h0, if_instr}, 64'h0);
        step();
        rst = 1'b0;
        step();     // IDLE -> REQ

        // ready held low: request stays up, address stable
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req_valid", {63'h0, imem_req_valid}, 64'h1);
            chk("stall_req_addr", imem_req_addr, 64'h8000_0000);
            step();
        end

        // Back-to-back fetches, latency 1
        exp_req_q.push_back(64'h8000_0000);
        exp_req_q.push_back(64'h8000_0004);
        exp_req_q.push_back(64'h8000_0008);
        push_if(64'h8000_0000, 32'h9000_0000, 1'b0);
        push_if(64'h8000_0004, 32'h9000_0004, 1'b0);
        push_if(64'h8000_0008, 32'h9000_0008, 1'b0);
        imem_req_ready = 1'b1;
        wait_req_drain();
        imem_req_ready = 1'b0;
        wait_if_drain();

        // Redirect while waiting on the response: response must be dropped
        exp_req_q.push_back(64'h8000_000C);
        exp_req_q.push_back(64'h8000_0100);
        push_if(64'h8000_0100, 32'h9000_0100, 1'b0);
        rsp_lat = 3;
        imem_req_ready = 1'b1;
        step();     // accepted, now in WAIT
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        @(negedge clk);
        chk("wait_redir_if_valid", {63'h0, if_valid}, 64'h0);
        step();
        redirect_valid = 1'b0;
        id_block       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drop_if_valid", {63'h0, if_valid}, 64'h0);
        end

        // Decode stall: held instruction stays stable
        wait_if_valid();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("hold_if_valid", {63'h0, if_valid}, 64'h1);
            chk("hold_if_pc", if_pc, 64'h8000_0100);
            chk("hold_if_instr", {32'h0, if_instr}, 64'h9000_0100);
        end
        exp_req_q.push_back(64'h8000_0104);
        step();
        id_block = 1'b0;
        step();
        id_block = 1'b1;

        // Redirect in HOLD under stall: squashed same cycle, next req = target
        wait_if_valid();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        exp_req_q.push_back(64'h8000_0200);
        push_if(64'h8000_0200, 32'h9000_0200, 1'b0);
        @(negedge clk);
        chk("hold_redir_if_valid", {63'h0, if_valid}, 64'h0);
        step();
        redirect_valid = 1'b0;
        id_block       = 1'b0;
        wait_req_drain();
        imem_req_ready = 1'b0;
        wait_if_drain();

        // Redirect before acceptance; target low bits ignored; PC wraps past 2^64
        rsp_lat = 1;
        exp_req_q.push_back(64'h8000_0204);
        exp_req_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_req_q.push_back(64'h0);
        push_if(64'hFFFF_FFFF_FFFF_FFFC, 32'h0FFF_FFFC, 1'b0);
        push_if(64'h0, 32'h1000_0000, 1'b0);
        redirect_valid = 1'b1;
`ifdef IFU_MISALIGN_TRAP_EN
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
`else
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
`endif
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        wait_req_drain();
        imem_req_ready = 1'b0;
        wait_if_drain();

        // Reset mid-flight; late response lands in IDLE and is ignored
        exp_req_q.push_back(64'h4);
        rsp_lat = 3;
        imem_req_ready = 1'b1;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("midrst_req_addr", imem_req_addr, 64'h8000_0000);
        chk("midrst_if_valid", {63'h0, if_valid}, 64'h0);
        chk("midrst_if_pc", if_pc, 64'h8000_0000);
        step();
        step();
        rst = 1'b0;
        imem_req_ready = 1'b0;
        step();
        @(negedge clk);
        chk("postrst_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("postrst_req_addr", imem_req_addr, 64'h8000_0000);
        chk("postrst_if_valid", {63'h0, if_valid}, 64'h0);
        step();
        rsp_lat = 1;
        exp_req_q.push_back(64'h8000_0000);
        push_if(64'h8000_0000, 32'h9000_0000, 1'b0);
        imem_req_ready = 1'b1;
        wait_req_drain();
        imem_req_ready = 1'b0;
        wait_if_drain();

`ifdef IFU_MISALIGN_TRAP_EN
        // Misaligned redirect from HOLD: fault instruction, no memory request
        exp_req_q.push_back(64'h8000_0004);
        id_block = 1'b1;
        imem_req_ready = 1'b1;
        wait_req_drain();
        imem_req_ready = 1'b0;
        wait_if_valid();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("mis_if_valid", {63'h0, if_valid}, 64'h1);
        chk("mis_flag", {63'h0, if_misalign}, 64'h1);
        chk("mis_if_pc", if_pc, 64'h8000_0102);
        chk("mis_if_instr", {32'h0, if_instr}, 64'h0000_0013);
        chk("mis_req_valid", {63'h0, imem_req_valid}, 64'h0);
        push_if(64'h8000_0102, 32'h0000_0013, 1'b1);
        step();
        id_block = 1'b0;
        wait_if_drain();
`endif

        repeat (3) step();
        chk("end_req_q_empty", 64'(exp_req_q.size()), 64'h0);
        chk("end_if_q_empty", 64'(exp_if_q.size()), 64'h0);
        summary();
        $finish;
    end

endmodule
